alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the combinational 32-bit ALU.
- Keeps the 4-bit ALUC operation encoding.
- Adds a valid/ready handshake on both sides, generic data width, a sideband tag, status flags (carry, zero, negative, overflow) and an illegal-op error flag.
- Sits between the decode/issue stage and writeback. Throughput is 1 op/cycle; latency is 2 cycles.

---
 rtl/alu_pipe.sv | 196 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready handshakes.
//
// Stage 1 captures the operands, tag and decoded operation. Stage 2 computes
// the result and status flags from the stage-1 registers and holds them at the
// output until the consumer takes them. Throughput is one op per cycle. An op
// accepted at rising edge N is presented with out_valid high for sampling at
// edge N+2.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   op presented on A / B / ALUC / in_tag
//   in_ready   block accepts the op this cycle
//   A          operand A (shift amount for shifts)
//   B          operand B (value being shifted for shifts)
//   ALUC       4-bit operation select
//   in_tag     opaque tag, returned unchanged with the result
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   OUT        result
//   out_tag    tag of the result
//   CARRY      add: carry-out, sub: borrow (A < B unsigned), else 0
//   OVF        signed overflow for add/sub, else 0
//   ZERO       OUT == 0
//   NEG        OUT[DATA_WDTH-1]
//   ERR        op was illegal (ALUC == 4'b1011)
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int DATA_WDTH  = 32,
  parameter int TAG_WDTH   = 4,
  parameter int SHAMT_WDTH = $clog2(DATA_WDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_WDTH-1:0] A,
  input  logic [DATA_WDTH-1:0] B,
  input  logic [3:0]           ALUC,
  input  logic [TAG_WDTH-1:0]  in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_WDTH-1:0] OUT,
  output logic [TAG_WDTH-1:0]  out_tag,
  output logic                 CARRY,
  output logic                 OVF,
  output logic                 ZERO,
  output logic                 NEG,
  output logic                 ERR
);

  localparam int HALF = DATA_WDTH / 2;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_XOR,
    OP_AND,
    OP_OR,
    OP_LUI,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_ILL
  } op_e;

  // Bit 3 is a don't-care except for the shift group (x11), where it splits
  // sll / illegal and srl / sra.
  function automatic op_e decode(input logic [3:0] aluc);
    op_e op;
    case (aluc[2:0])
      3'b000:  op = OP_ADD;
      3'b100:  op = OP_SUB;
      3'b010:  op = OP_XOR;
      3'b001:  op = OP_AND;
      3'b101:  op = OP_OR;
      3'b110:  op = OP_LUI;
      3'b011:  op = aluc[3] ? OP_ILL : OP_SLL;
      3'b111:  op = aluc[3] ? OP_SRA : OP_SRL;
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

  // -------------------------------------------------------------------------
  // Stage 1: operand / tag capture and decode
  // -------------------------------------------------------------------------
  logic                 s1_vld;
  logic [DATA_WDTH-1:0] s1_a;
  logic [DATA_WDTH-1:0] s1_b;
  logic [TAG_WDTH-1:0]  s1_tag;
  op_e                  s1_op;

  logic s2_accept;

  // Stage 2 frees up when empty or when its result leaves this cycle.
  assign s2_accept = !out_valid || out_ready;
  // Stage 1 frees up when empty or when its op moves into stage 2; no path
  // from in_valid, only the ready chain from out_ready.
  assign in_ready  = !s1_vld || s2_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
      s1_op  <= OP_ADD;
    end else if (in_ready) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a   <= A;
        s1_b   <= B;
        s1_tag <= in_tag;
        s1_op  <= decode(ALUC);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Execute (combinational from stage-1 registers)
  // -------------------------------------------------------------------------
  logic [DATA_WDTH:0]     sum_ext;
  logic [DATA_WDTH:0]     diff_ext;
  logic [SHAMT_WDTH-1:0]  shamt;
  logic [DATA_WDTH-1:0]   res;
  logic                   res_carry;
  logic                   res_ovf;
  logic                   res_err;

  // One extra bit catches the carry-out; for subtraction it is the borrow.
  assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_ext = {1'b0, s1_a} - {1'b0, s1_b};
  assign shamt    = s1_a[SHAMT_WDTH-1:0];

  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res       = sum_ext[DATA_WDTH-1:0];
        res_carry = sum_ext[DATA_WDTH];
        // Same-sign operands producing an opposite-sign result.
        res_ovf   = (s1_a[DATA_WDTH-1] == s1_b[DATA_WDTH-1]) &&
                    (sum_ext[DATA_WDTH-1] != s1_a[DATA_WDTH-1]);
      end
      OP_SUB: begin
        res       = diff_ext[DATA_WDTH-1:0];
        res_carry = diff_ext[DATA_WDTH];
        // Different-sign operands where the result sign differs from A.
        res_ovf   = (s1_a[DATA_WDTH-1] != s1_b[DATA_WDTH-1]) &&
                    (diff_ext[DATA_WDTH-1] != s1_a[DATA_WDTH-1]);
      end
      OP_XOR: res = s1_a ^ s1_b;
      OP_AND: res = s1_a & s1_b;
      OP_OR:  res = s1_a | s1_b;
      OP_LUI: res = {s1_b[HALF-1:0], {HALF{1'b0}}};
      OP_SLL: res = s1_b << shamt;
      OP_SRL: res = s1_b >> shamt;
      OP_SRA: res = $unsigned($signed(s1_b) >>> shamt);
      OP_ILL: res_err = 1'b1;
      default: res_err = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 2: result / flag registers, held while the consumer stalls
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      OUT       <= '0;
      out_tag   <= '0;
      CARRY     <= 1'b0;
      OVF       <= 1'b0;
      ZERO      <= 1'b0;
      NEG       <= 1'b0;
      ERR       <= 1'b0;
    end else if (s2_accept) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        OUT     <= res;
        out_tag <= s1_tag;
        CARRY   <= res_carry;
        OVF     <= res_ovf;
        ZERO    <= (res == '0);
        NEG     <= res[DATA_WDTH-1];
        ERR     <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- scoreboard bench for alu_pipe (DATA_WDTH=32, TAG_WDTH=4).
// The driver pushes the expected response when an op is accepted; a monitor
// compares every presented result against the head of the queue and pops it
// when the consumer takes it. Directed ops carry hand-written expectations,
// random ops use an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  out;
    logic [TW-1:0] tag;
    logic          carry;
    logic          ovf;
    logic          zero;
    logic          neg;
    logic          err;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [3:0]    ALUC;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  OUT;
  logic [TW-1:0] out_tag;
  logic          CARRY;
  logic          OVF;
  logic          ZERO;
  logic          NEG;
  logic          ERR;

  alu_pipe #(.DATA_WDTH(W), .TAG_WDTH(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUC      (ALUC),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (OUT),
    .out_tag   (out_tag),
    .CARRY     (CARRY),
    .OVF       (OVF),
    .ZERO      (ZERO),
    .NEG       (NEG),
    .ERR       (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors  = 0;
  int   checks  = 0;
  int   pop_cnt = 0;
  bit   rand_rdy = 1'b0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Expected response built from an explicit result and carry/ovf/err bits.
  function automatic exp_t mk(input logic [W-1:0] out, input logic [TW-1:0] tag,
                              input logic c, input logic o, input logic e);
    exp_t x;
    x.out   = out;
    x.tag   = tag;
    x.carry = c;
    x.ovf   = o;
    x.err   = e;
    x.zero  = (out == 0);
    x.neg   = out[W-1];
    return x;
  endfunction

  // Reference model: plain wide integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] aluc, input logic [TW-1:0] tag);
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint sa = longint'($signed(a));
    longint sb_ = longint'($signed(b));
    longint r;
    int     sh = int'(a[4:0]);
    logic [W-1:0] o = '0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic e = 1'b0;
    if (aluc == 4'b1011) begin
      e = 1'b1;
    end else if (aluc[2:0] == 3'b000) begin
      r = ua + ub;
      o = r[W-1:0];
      c = (r >= 64'sh1_0000_0000);
      r = sa + sb_;
      v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    end else if (aluc[2:0] == 3'b100) begin
      r = ua - ub;
      o = r[W-1:0];
      c = (ua < ub);
      r = sa - sb_;
      v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    end else if (aluc[2:0] == 3'b010) o = a ^ b;
    else if (aluc[2:0] == 3'b001) o = a & b;
    else if (aluc[2:0] == 3'b101) o = a | b;
    else if (aluc[2:0] == 3'b110) o = b << 16;
    else if (aluc == 4'b0011)     o = b << sh;
    else if (aluc == 4'b0111)     o = b >> sh;
    else                          o = $unsigned($signed(b) >>> sh);
    return mk(o, tag, c, v, e);
  endfunction

  // Inputs change 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Presents an op and waits (bounded) for acceptance; in_valid is left high
  // so consecutive calls stream back-to-back.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] aluc, input logic [TW-1:0] tag, input exp_t e);
    int waits = 0;
    in_valid = 1'b1;
    A        = a;
    B        = b;
    ALUC     = aluc;
    in_tag   = tag;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 100) begin
        check("send_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    sb.push_back(e);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every cycle a result is presented it must match the queue head,
  // including while stalled (stability); pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        check(out_ready ? "result" : "held_result",
              {23'd0, OUT, out_tag, CARRY, OVF, ZERO, NEG, ERR}, {23'd0, sb[0]});
        if (out_ready) begin
          $display("txn tag=%0d out=%h c=%0b v=%0b z=%0b n=%0b e=%0b",
                   out_tag, OUT, CARRY, OVF, ZERO, NEG, ERR);
          void'(sb.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rc;
    logic [TW-1:0] rt;

    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    ALUC = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_outputs", {23'd0, OUT, out_tag, CARRY, OVF, ZERO, NEG, ERR}, 64'd0);
    tick();

    // Single add and its latency
    send(32'd3, 32'd8, 4'b0000, 4'd5, mk(32'd11, 4'd5, 1'b0, 1'b0, 1'b0));
    idle();
    @(negedge clk);
    check("lat_edge_n1", {63'd0, out_valid}, 64'd0);
    tick();
    @(negedge clk);
    check("lat_edge_n2", {63'd0, out_valid}, 64'd1);
    tick();

    // Directed operations, streamed back-to-back
    send(32'hFFFF_FFFF, 32'd1, 4'b1000, 4'd1, mk(32'h0, 4'd1, 1'b1, 1'b0, 1'b0));
    send(32'h7FFF_FFFF, 32'd1, 4'b0000, 4'd2, mk(32'h8000_0000, 4'd2, 1'b0, 1'b1, 1'b0));
    send(32'd8, 32'd11, 4'b0100, 4'd3, mk(32'hFFFF_FFFD, 4'd3, 1'b1, 1'b0, 1'b0));
    send(32'd11, 32'hFFFF_FFF8, 4'b1111, 4'd4, mk(32'hFFFF_FFFF, 4'd4, 1'b0, 1'b0, 1'b0));
    send(32'd11, 32'hFFFF_FFF8, 4'b0111, 4'd6, mk(32'h001F_FFFF, 4'd6, 1'b0, 1'b0, 1'b0));
    send(32'h23, 32'd1, 4'b0011, 4'd7, mk(32'd8, 4'd7, 1'b0, 1'b0, 1'b0));
    send(32'd0, 32'h1234_ABCD, 4'b0110, 4'd8, mk(32'hABCD_0000, 4'd8, 1'b0, 1'b0, 1'b0));
    send(32'd11, 32'd8, 4'b1011, 4'd9, mk(32'h0, 4'd9, 1'b0, 1'b0, 1'b1));
    send(32'd5, 32'd3, 4'b1010, 4'd10, mk(32'd6, 4'd10, 1'b0, 1'b0, 1'b0));
    send(32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0001, 4'd11, mk(32'h00F0_000F, 4'd11, 1'b0, 1'b0, 1'b0));
    send(32'hF000_0000, 32'h0000_000F, 4'b1101, 4'd12, mk(32'hF000_000F, 4'd12, 1'b0, 1'b0, 1'b0));
    send(32'h8000_0000, 32'd1, 4'b1100, 4'd13, mk(32'h7FFF_FFFF, 4'd13, 1'b0, 1'b1, 1'b0));
    idle();
    drain();

    // Backpressure: two ops fill the pipe, in_ready drops, results hold
    out_ready = 1'b0;
    tick();
    send(32'd100, 32'd1, 4'b0000, 4'd0, mk(32'd101, 4'd0, 1'b0, 1'b0, 1'b0));
    send(32'd100, 32'd2, 4'b0000, 4'd1, mk(32'd102, 4'd1, 1'b0, 1'b0, 1'b0));
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      tick();
    end
    snap = pop_cnt;
    out_ready = 1'b1;
    send(32'd100, 32'd3, 4'b0000, 4'd2, mk(32'd103, 4'd2, 1'b0, 1'b0, 1'b0));
    send(32'd100, 32'd4, 4'b0000, 4'd3, mk(32'd104, 4'd3, 1'b0, 1'b0, 1'b0));
    send(32'd100, 32'd5, 4'b0000, 4'd4, mk(32'd105, 4'd4, 1'b0, 1'b0, 1'b0));
    send(32'd100, 32'd6, 4'b0000, 4'd5, mk(32'd106, 4'd5, 1'b0, 1'b0, 1'b0));
    idle();
    tick();
    tick();
    check("bp_one_per_cycle", 64'(pop_cnt - snap), 64'd6);
    drain();

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(32'd7, 32'd7, 4'b0000, 4'd14, mk(32'd14, 4'd14, 1'b0, 1'b0, 1'b0));
    send(32'd9, 32'd9, 4'b0000, 4'd15, mk(32'd18, 4'd15, 1'b0, 1'b0, 1'b0));
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_outputs", {23'd0, OUT, out_tag, CARRY, OVF, ZERO, NEG, ERR}, 64'd0);
    check("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    snap = pop_cnt;
    tick();
    send(32'd1, 32'd2, 4'b0000, 4'd6, mk(32'd3, 4'd6, 1'b0, 1'b0, 1'b0));
    idle();
    drain();
    repeat (3) tick();
    check("rst_no_stale", 64'(pop_cnt - snap), 64'd1);

    // Randomized stream with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'h0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h7FFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rc = 4'($urandom_range(0, 15));
      rt = 4'($urandom_range(0, 15));
      send(ra, rb, rc, rt, model(ra, rb, rc, rt));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick();
      end
    end
    idle();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
